setpoint_adjust: RTL

Generates the user-selected target temperature (deg F, unsigned 8-bit) from the Nexys up/down push-buttons. Raw buttons are synchronized and debounced. A single press steps the setpoint by one, and a held button auto-repeats. The result feeds the set-temperature input of the display-select stage and the thermostat compare logic, alongside the current-temperature byte from the I2C master.

---
 rtl/setpoint_adjust.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/setpoint_adjust.sv
// Button-driven thermostat setpoint: sync + debounce, single step per press, auto-repeat while held.
// set_temp moves on the 2nd edge after a debounced press edge; both buttons held locks out stepping.
module setpoint_adjust #(
  parameter int          DEBOUNCE_CYCLES     = 1_000_000,
  parameter int          REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int          REPEAT_RATE_CYCLES  = 10_000_000,
  parameter logic [7:0]  TEMP_MIN            = 8'd50,
  parameter logic [7:0]  TEMP_MAX            = 8'd90,
  parameter logic [7:0]  TEMP_DEFAULT        = 8'd70
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       adjust_en,
  output logic [7:0] set_temp,
  output logic       set_changed,
  output logic       at_limit
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ? REPEAT_DELAY_CYCLES
                                                                     : REPEAT_RATE_CYCLES;
  localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, STEP, HOLD, REPEAT, LOCK} state_t;

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0]      raw, sync_a, sync_b, deb, deb_q, rise;
  logic [DB_W-1:0] db_cnt [2];

  assign raw = {btn_down, btn_up};

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync_a    <= '0;
      sync_b    <= '0;
      deb       <= '0;
      deb_q     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      deb_q  <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = deb & ~deb_q;

  state_t          state, next_state;
  logic            dir_up;
  logic [RP_W-1:0] rep_cnt;
  logic            both, held, step_en;

  assign both = deb[0] & deb[1];
  assign held = dir_up ? deb[0] : deb[1];

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (!adjust_en) begin
      next_state = IDLE;
    end else if (both) begin
      next_state = LOCK;
    end else begin
      case (state)
        IDLE:    if (rise[0] ^ rise[1]) next_state = STEP;
        STEP:    next_state = HOLD;
        HOLD: begin
          if (!held)                      next_state = IDLE;
          else if (rep_cnt == DELAY_LAST) next_state = REPEAT;
        end
        REPEAT:  if (!held) next_state = IDLE;
        LOCK:    if (!deb[0] && !deb[1]) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    step_en = 1'b0;
    if (adjust_en && !both) begin
      case (state)
        STEP:    step_en = 1'b1;
        HOLD:    step_en = held && (rep_cnt == DELAY_LAST);
        REPEAT:  step_en = held && (rep_cnt == RATE_LAST);
        default: step_en = 1'b0;
      endcase
    end
  end

  // Repeat counter runs only while parked in HOLD/REPEAT; any step or state change restarts it.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      dir_up  <= 1'b0;
      rep_cnt <= '0;
    end else begin
      if (state == IDLE && next_state == STEP) dir_up <= rise[0];
      if ((state == HOLD || state == REPEAT) && next_state == state && !step_en)
        rep_cnt <= rep_cnt + 1'b1;
      else
        rep_cnt <= '0;
    end
  end

  logic [7:0] temp_nxt;
  logic       temp_chg;

  always_comb begin
    temp_nxt = set_temp;
    temp_chg = 1'b0;
    if (step_en) begin
      if (dir_up && set_temp < TEMP_MAX) begin
        temp_nxt = set_temp + 8'd1;
        temp_chg = 1'b1;
      end else if (!dir_up && set_temp > TEMP_MIN) begin
        temp_nxt = set_temp - 8'd1;
        temp_chg = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      set_temp    <= TEMP_DEFAULT;
      set_changed <= 1'b0;
      at_limit    <= (TEMP_DEFAULT == TEMP_MIN) || (TEMP_DEFAULT == TEMP_MAX);
    end else begin
      set_temp    <= temp_nxt;
      set_changed <= temp_chg;
      at_limit    <= (temp_nxt == TEMP_MIN) || (temp_nxt == TEMP_MAX);
    end
  end

endmodule
